// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter fed by a small byte FIFO.
// Registers DATA/STATUS/DIV/CTRL at BASE..BASE+3; rd and hit decode combinationally from adr.
// tx is registered one clock behind the FSM; frames run back-to-back while EN=1 and bytes remain.
module mmio_uart_tx #(
  parameter logic [7:0] BASE      = 8'hF0,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] adr,
  input  logic [7:0] wd,
  output logic [7:0] rd,
  output logic       hit,
  output logic       tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, en_q;
  logic [7:0]    divr_q;            // software-visible divisor
  logic [7:0]    div_q, div_d;      // divisor frozen for the frame in flight
  logic [7:0]    bitcnt_q, bitcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic [7:0]    off;
  logic          wr_data, wr_status, wr_div, wr_ctrl;
  logic          full, empty, pop, push_ok, bit_done;

  assign off       = adr - BASE;
  assign hit       = (off < 8'd4);
  assign wr_data   = we && hit && (off[1:0] == 2'd0);
  assign wr_status = we && hit && (off[1:0] == 2'd1);
  assign wr_div    = we && hit && (off[1:0] == 2'd2);
  assign wr_ctrl   = we && hit && (off[1:0] == 2'd3);

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = wr_data && (!full || pop);
  assign bit_done  = (bitcnt_q == div_q);
  assign tx        = tx_q;

  // Combinational register read mux; unmapped addresses read zero.
  always_comb begin
    rd = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd1:    rd = {4'(count_q), ovf_q, empty, full, (state_q != IDLE)};
        2'd2:    rd = divr_q;
        2'd3:    rd = {7'b0, en_q};
        default: rd = 8'h00;
      endcase
    end
  end

  // Software registers: divisor, enable and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      divr_q <= DIV_RESET;
      en_q   <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_div)  divr_q <= wd;
      if (wr_ctrl) en_q   <= wd[0];
      if (wr_status)                    ovf_q <= 1'b0;
      else if (wr_data && full && !pop) ovf_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wd;
  end

  // Next-state logic: each frame phase lasts div_q+1 clocks per bit.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    div_d    = div_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && !empty) begin
          pop      = 1'b1;
          sh_d     = mem_q[rptr_q];
          div_d    = divr_q;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          bitcnt_d = '0;
          idx_d    = '0;
          state_d  = DATA;
        end else begin
          bitcnt_d = bitcnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bitcnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          bitcnt_d = bitcnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bitcnt_d = '0;
          if (en_q && !empty) begin
            pop     = 1'b1;
            sh_d    = mem_q[rptr_q];
            div_d   = divr_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current phase and is registered, so tx lags the FSM by one clock.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  // FSM and serialiser state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      div_q    <= DIV_RESET;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a frame-level model (byte queue + time-within-frame).
module tb_mmio_uart_tx;
  localparam logic [7:0] BASE      = 8'hF0;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] DIV_RESET = 8'd3;

  logic       clk = 1'b0;
  logic       reset, we, hit, tx;
  logic [7:0] adr, wd, rd;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(.BASE(BASE), .DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .clk(clk), .reset(reset), .we(we), .adr(adr), .wd(wd),
    .rd(rd), .hit(hit), .tx(tx)
  );

  always #5 clk = ~clk;

  // Model: FIFO as a queue, transmitter as (busy, cycles since pop, byte, divisor).
  logic [7:0] q[$];
  bit         m_ovf, m_en, m_busy, m_tx, model_ok;
  logic [7:0] m_div, m_fdiv, m_byte;
  int         m_t;

  logic [0:9]  p1 = 10'b0101001011;
  logic [0:29] p2 = 30'b0100000001_0010000001_0110000001;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit frame_bit(int t);
    int k;
    k = t / (int'(m_fdiv) + 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic bit exp_hit(logic [7:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
  endfunction

  function automatic logic [7:0] exp_rd(logic [7:0] a);
    int o;
    o = int'(a) - int'(BASE);
    case (o)
      1: return {4'(q.size()), m_ovf, q.size() == 0, q.size() == DEPTH, m_busy};
      2: return m_div;
      3: return {7'b0, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit pop;
    int len;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_en = 1; m_div = DIV_RESET; m_busy = 0; m_t = 0; m_tx = 1;
      model_ok = 1;
    end else begin
      m_tx = m_busy ? frame_bit(m_t) : 1'b1;
      len  = 10 * (int'(m_fdiv) + 1);
      pop  = (!m_busy || m_t == len - 1) && m_en && (q.size() > 0);
      if (pop) begin
        m_byte = q.pop_front(); m_fdiv = m_div; m_t = 0; m_busy = 1;
      end else if (m_busy) begin
        if (m_t == len - 1) m_busy = 0;
        else                m_t++;
      end
      if (we && adr == BASE) begin
        if (q.size() < DEPTH) q.push_back(wd);
        else                  m_ovf = 1;
      end
      if (we && adr == BASE + 8'd1) m_ovf = 0;
      if (we && adr == BASE + 8'd2) m_div = wd;
      if (we && adr == BASE + 8'd3) m_en  = wd[0];
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("tx",  {7'b0, tx},  {7'b0, m_tx});
      chk("hit", {7'b0, hit}, {7'b0, exp_hit(adr)});
      chk("rd",  rd, exp_rd(adr));
    end
  end

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit after.
  task automatic cyc(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    reset = r; we = w; adr = a; wd = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [7:0] rand_adr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return BASE + 8'($urandom_range(0, 3));
  endfunction

  task automatic idle();
    cyc(0, 0, rand_adr(), 8'($urandom));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(0, 1, a, d);
  endtask

  task automatic rdchk(input string name, input logic [7:0] a, input bit eh, input logic [7:0] exp);
    reset = 0; we = 0; adr = a;
    #1;
    chk(name, rd, exp);
    chk({name, "_hit"}, {7'b0, hit}, {7'b0, eh});
    cyc(0, 0, a, 8'h00);
  endtask

  task automatic wait_tx(input bit lvl, input int bound, output int n);
    n = 0;
    while (tx !== lvl && n < bound) begin idle(); n++; end
    chk("wait_tx", {7'b0, tx}, {7'b0, lvl});
  endtask

  task automatic low_run(output int len);
    len = 0;
    while (tx === 1'b0 && len < 100) begin idle(); len++; end
  endtask

  initial begin
    int n, len;
    reset = 1; we = 0; adr = 0; wd = 0;
    #1;
    cyc(1, 0, 8'h00, 8'h00);
    cyc(1, 0, 8'h00, 8'h00);

    // Scenario 1: single 0xA5 frame at DIV=3.
    chk("reset_tx", {7'b0, tx}, 8'h01);
    rdchk("reset_status", BASE + 8'd1, 1, 8'h04);
    wr(BASE, 8'hA5);
    wait_tx(0, 10, n);
    chk("fall_latency", 8'(n), 8'd2);
    for (int i = 0; i < 40; i++) begin
      we = 0; adr = BASE + 8'd1;
      #1;
      chk("a5_bit", {7'b0, tx}, {7'b0, p1[i/4]});
      if (i < 39) chk("a5_busy", {7'b0, rd[0]}, 8'h01);
      cyc(0, 0, BASE + 8'd1, 8'h00);
    end
    chk("a5_idle_tx", {7'b0, tx}, 8'h01);
    rdchk("a5_status_end", BASE + 8'd1, 1, 8'h04);

    // Scenario 2: three back-to-back frames at DIV=0.
    wr(BASE + 8'd2, 8'h00);
    wr(BASE, 8'h01); wr(BASE, 8'h02); wr(BASE, 8'h03);
    wait_tx(0, 10, n);
    for (int i = 0; i < 30; i++) begin
      chk("b2b_bit", {7'b0, tx}, {7'b0, p2[i]});
      idle();
    end
    rdchk("b2b_status", BASE + 8'd1, 1, 8'h04);

    // Scenario 3: overflow with EN=0, then clear OVF.
    wr(BASE + 8'd3, 8'h00);
    for (int i = 0; i < 5; i++) wr(BASE, 8'($urandom));
    rdchk("ovf_status", BASE + 8'd1, 1, 8'h4A);
    chk("ovf_tx", {7'b0, tx}, 8'h01);
    wr(BASE + 8'd1, 8'hFF);
    rdchk("ovf_cleared", BASE + 8'd1, 1, 8'h42);

    // Scenario 4: push into a full FIFO on the pop edge is accepted.
    wr(BASE + 8'd3, 8'h01);
    wr(BASE, 8'h55);
    rdchk("full_pop_push", BASE + 8'd1, 1, 8'h43);
    repeat (60) idle();
    rdchk("drained", BASE + 8'd1, 1, 8'h04);

    // Scenario 5: DIV change mid-frame applies to the next frame only.
    wr(BASE + 8'd2, 8'h03);
    wr(BASE, 8'hFF);
    wait_tx(0, 10, n);
    low_run(len);
    chk("div3_start_len", 8'(len), 8'd4);
    wr(BASE + 8'd2, 8'h07);
    wr(BASE, 8'hFF);
    wait_tx(0, 100, n);
    low_run(len);
    chk("div7_start_len", 8'(len), 8'd8);
    rdchk("div_read", BASE + 8'd2, 1, 8'h07);
    repeat (80) idle();

    // Scenario 6: reset in the middle of DATA.
    wr(BASE + 8'd2, 8'h05);
    wr(BASE, 8'h3C);
    repeat (12) idle();
    cyc(1, 0, 8'h00, 8'h00);
    chk("rst_tx", {7'b0, tx}, 8'h01);
    rdchk("rst_status", BASE + 8'd1, 1, 8'h04);
    rdchk("rst_div",    BASE + 8'd2, 1, 8'h03);
    rdchk("rst_ctrl",   BASE + 8'd3, 1, 8'h01);
    rdchk("unmapped",   8'h10,       0, 8'h00);

    // Random phase: mixed register traffic, occasional reset; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 99);
      a = BASE + 8'($urandom_range(0, 3));
      if (r < 2)       cyc(1, 0, rand_adr(), 8'h00);
      else if (r < 30) begin
        if (a == BASE + 8'd2) wr(a, 8'($urandom_range(0, 3)));
        else if (a == BASE + 8'd3) wr(a, ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h01);
        else wr(a, 8'($urandom));
      end
      else idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
